instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage: owns the program counter and issues one 32-bit instruction request at a time to instruction memory. It buffers each returned word in a single-entry output register and presents it as `inst_code` with a valid/ready handshake to the decode stage, which holds `imm_Gen` and the control decoder. Branch and jump targets are computed downstream as PC + immediate and return to this block as a redirect, which flushes fetched-but-unconsumed work.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.

Ports:
- `clk`  in  1: single clock, all state on rising edge.
- `reset`  in  1: synchronous, active-high.
- `imem_req`  out  1: fetch request.
- `imem_addr`  out  32: word-aligned fetch address, valid while `imem_req`.
- `imem_gnt`  in  1: memory accepts the request this cycle.
- `imem_rvalid`  in  1: response valid; at least 1 cycle after the grant.
- `imem_rdata`  in  32: instruction word, valid with `imem_rvalid`.
- `redirect`  in  1: taken branch or jump from a later stage.
- `redirect_pc`  in  32: new PC; bits [1:0] are ignored and forced to 00.
- `inst_valid`  out  1: `inst_code`/`inst_pc` hold a live instruction.
- `id_ready`  in  1: decode accepts; transfer = `inst_valid && id_ready`.
- `inst_code`  out  32: instruction word to decode/`imm_Gen`.
- `inst_pc`  out  32: address of `inst_code`.
- `fetch_count`  out  32: number of completed transfers to decode; wraps modulo 2^32.

## Operation
- FSM states FETCH and WAIT. Reset → FETCH, `pc`=RESET_PC, `kill`=0.
- FETCH: `imem_req` = `!inst_valid || id_ready`, so a request issues only if the buffer is empty or drains this cycle. `imem_addr`=`pc`. On `imem_req && imem_gnt`: `req_pc`←`pc`, `pc`←`pc`+4 (wraps at 2^32), go to WAIT.
- WAIT: `imem_req`=0. On `imem_rvalid`:
  - If `kill`=0: `inst_code`←`imem_rdata`, `inst_pc`←`req_pc`, `inst_valid`←1.
  - If `kill`=1: drop the response and clear `kill`.
  - Either way, go to FETCH.
- Only one request is outstanding at a time. `imem_rvalid` seen in FETCH is a stray and is ignored.
- Transfer (`inst_valid && id_ready`) with no new fill this cycle: `inst_valid`←0. `fetch_count` increments on every transfer.
- Redirect has priority over all other updates in its cycle:
  - `pc`←{`redirect_pc`[31:2],2'b00}.
  - `inst_valid`←0 and `inst_code`←32'h0000_0013 (NOP).
  - An instruction transferring in the same cycle still counts; decode has taken it.
  - In WAIT without `imem_rvalid`: `kill`←1.
  - In WAIT with `imem_rvalid`: the response is dropped and the FSM goes to FETCH.
  - In FETCH with a grant: the grant goes out for the old `pc`. The FSM goes to WAIT with `kill`←1, and the new `pc` is not incremented.
- Reset mid-operation: all state returns to reset values and any pending response is forgotten. The memory is reset by the same `reset`.

## Timing
- Reset values:
  - `imem_req`=1 in the first cycle out of reset (FETCH, buffer empty).
  - `imem_addr`=RESET_PC.
  - `inst_valid`=0, `inst_code`=32'h0000_0013, `inst_pc`=0, `fetch_count`=0.
  - `pc`=RESET_PC, `kill`=0.
- `imem_req` and `imem_addr` are combinational from state and `id_ready` only. There is no path from `redirect` or `imem_rvalid` to `imem_req`.
- `inst_*` and `fetch_count` are registered.
- Latency with `imem_gnt`=1 and `imem_rvalid` one cycle after grant:
  - Request in cycle N, response in N+1, `inst_valid` in N+2, next request in N+2.
  - Peak throughput is 1 instruction per 2 cycles.
- A redirect in cycle N puts `redirect_pc` on `imem_addr` no later than cycle N+2, even with a killed response in flight.

## Structure
- Shared package `fetch_pkg`:
  - enum `fetch_state_t` {FETCH, WAIT}.
  - `INST_NOP` = 32'h0000_0013.
  - `INST_BYTES` = 4.
- No sub-module. The FSM, PC, kill flag, output buffer and counter form one module of about 150 lines.

## Test plan
- Reset release, `RESET_PC`=32'h100, gnt=1, rvalid 1 cycle after grant, `id_ready`=1. Required: addresses 0x100, 0x104, 0x108 issued on alternate cycles; `inst_pc` follows the same sequence; `fetch_count`=3 after the third transfer.
- `id_ready`=0 for 5 cycles with an instruction held. Required: `inst_code` and `inst_pc` stable, `imem_req`=0 after the buffer fills, no new grant until `id_ready`=1.
- Redirect to 0x0000_0203 while in WAIT, with rvalid 2 cycles later carrying 0xDEADBEEF. Required: response dropped; next `imem_addr`=0x200; `inst_valid` stays 0 until the 0x200 word returns.
- Redirect coinciding with rvalid, and redirect coinciding with a grant. Required: no stale instruction is ever presented; `kill` clears after exactly one dropped response.
- Redirect and transfer in the same cycle at `fetch_count`=7. Required: count becomes 8 and `inst_code`=NOP with `inst_valid`=0.
- `reset` asserted mid-WAIT. Required: next cycle `imem_req`=1, `imem_addr`=RESET_PC, `fetch_count`=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage and its bench.
package fetch_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    WAIT  = 1'b1
  } fetch_state_t;

  localparam logic [31:0] INST_NOP   = 32'h0000_0013;
  localparam logic [31:0] INST_BYTES = 32'd4;

  // Instruction addresses are always word aligned; the low two bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, keeps one memory request in flight and
// buffers the returned word for decode behind a valid/ready handshake.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        id_ready,
  output logic [31:0] inst_code,
  output logic [31:0] inst_pc,
  output logic [31:0] fetch_count
);

  fetch_state_t state_r;
  logic [31:0]  pc_r;
  logic [31:0]  req_pc_r;
  logic         kill_r;
  logic         inst_valid_r;
  logic [31:0]  inst_code_r;
  logic [31:0]  inst_pc_r;
  logic [31:0]  fetch_count_r;

  logic         req_s;
  logic         grant_s;
  logic         xfer_s;
  logic         fill_s;

  // Request and handshake decode; the request never depends on redirect or rvalid.
  always_comb begin
    req_s = 1'b0;
    if (state_r == FETCH) begin
      req_s = !inst_valid_r || id_ready;
    end else begin
      req_s = 1'b0;
    end
    grant_s = req_s && imem_gnt;
    xfer_s  = inst_valid_r && id_ready;
    fill_s  = (state_r == WAIT) && imem_rvalid && !kill_r && !redirect;
  end

  assign imem_req    = req_s;
  assign imem_addr   = pc_r;
  assign inst_valid  = inst_valid_r;
  assign inst_code   = inst_code_r;
  assign inst_pc     = inst_pc_r;
  assign fetch_count = fetch_count_r;

  // Fetch FSM, PC, kill flag, output buffer and transfer counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= FETCH;
      pc_r          <= RESET_PC;
      req_pc_r      <= RESET_PC;
      kill_r        <= 1'b0;
      inst_valid_r  <= 1'b0;
      inst_code_r   <= INST_NOP;
      inst_pc_r     <= 32'h0000_0000;
      fetch_count_r <= 32'h0000_0000;
    end else begin
      // Decode has already taken a word transferring now, even under redirect.
      if (xfer_s) begin
        fetch_count_r <= fetch_count_r + 32'd1;
      end
      if (redirect) begin
        pc_r         <= word_align(redirect_pc);
        inst_valid_r <= 1'b0;
        inst_code_r  <= INST_NOP;
        case (state_r)
          FETCH: begin
            // The grant went out for the old PC; its response must be dropped.
            if (grant_s) begin
              req_pc_r <= pc_r;
              kill_r   <= 1'b1;
              state_r  <= WAIT;
            end
          end
          WAIT: begin
            if (imem_rvalid) begin
              kill_r  <= 1'b0;
              state_r <= FETCH;
            end else begin
              kill_r  <= 1'b1;
            end
          end
          default: begin
            kill_r  <= 1'b0;
            state_r <= FETCH;
          end
        endcase
      end else begin
        if (fill_s) begin
          inst_code_r  <= imem_rdata;
          inst_pc_r    <= req_pc_r;
          inst_valid_r <= 1'b1;
        end else if (xfer_s) begin
          inst_valid_r <= 1'b0;
        end
        case (state_r)
          FETCH: begin
            if (grant_s) begin
              req_pc_r <= pc_r;
              pc_r     <= pc_r + INST_BYTES;
              state_r  <= WAIT;
            end
          end
          WAIT: begin
            if (imem_rvalid) begin
              kill_r  <= 1'b0;
              state_r <= FETCH;
            end
          end
          default: begin
            kill_r  <= 1'b0;
            state_r <= FETCH;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a one-outstanding memory model plus a
// scoreboard of instructions expected at the decode handshake.
module tb_instr_fetch;
  import fetch_pkg::*;

  localparam logic [31:0] RPC = 32'h0000_0100;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] code;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        id_ready;
  logic [31:0] inst_code;
  logic [31:0] inst_pc;
  logic [31:0] fetch_count;

  int          checks = 0;
  int          errors = 0;
  exp_t        sb_q[$];
  logic [31:0] gnt_addr_log[$];
  int          gnt_cyc_log[$];
  int          cyc = 0;

  bit          m_busy = 1'b0;
  bit          m_killed = 1'b0;
  logic [31:0] m_addr = 32'h0;
  int          m_cnt = 0;
  int          mem_lat = 1;
  bit          ovr_en = 1'b0;
  logic [31:0] rdata_ovr = 32'h0;
  logic [31:0] exp_pc = RPC;
  logic [31:0] exp_count = 32'h0;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .id_ready(id_ready),
    .inst_code(inst_code), .inst_pc(inst_pc), .fetch_count(fetch_count)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0001;
  endfunction

  // Scoreboard and memory bookkeeping, run once per cycle at the falling edge.
  task automatic monitor_cycle();
    bit ev;
    bit er;
    bit gnt_now;
    cyc++;
    if (reset) begin
      sb_q.delete();
      m_busy    = 1'b0;
      m_killed  = 1'b0;
      exp_pc    = RPC;
      exp_count = 32'h0;
    end else begin
      ev = (sb_q.size() != 0);
      er = !m_busy && (!ev || id_ready);
      checks++;
      if (inst_valid !== ev) begin
        errors++; $display("FAIL inst_valid cyc %0d got %b exp %b", cyc, inst_valid, ev);
      end
      checks++;
      if (fetch_count !== exp_count) begin
        errors++; $display("FAIL fetch_count cyc %0d got %0d exp %0d", cyc, fetch_count, exp_count);
      end
      checks++;
      if (imem_req !== er) begin
        errors++; $display("FAIL imem_req cyc %0d got %b exp %b", cyc, imem_req, er);
      end
      if (er) begin
        checks++;
        if (imem_addr !== exp_pc) begin
          errors++; $display("FAIL imem_addr cyc %0d got %h exp %h", cyc, imem_addr, exp_pc);
        end
      end
      if (ev) begin
        checks++;
        if (inst_pc !== sb_q[0].pc || inst_code !== sb_q[0].code) begin
          errors++;
          $display("FAIL inst cyc %0d got pc %h code %h exp pc %h code %h",
                   cyc, inst_pc, inst_code, sb_q[0].pc, sb_q[0].code);
        end
        if (id_ready) begin
          void'(sb_q.pop_front());
          exp_count = exp_count + 32'd1;
        end
      end
      gnt_now = er && imem_gnt;
      if (gnt_now) begin
        gnt_addr_log.push_back(exp_pc);
        gnt_cyc_log.push_back(cyc);
      end
      if (redirect) begin
        sb_q.delete();
        if (gnt_now) begin
          m_busy = 1'b1; m_killed = 1'b1; m_addr = exp_pc; m_cnt = mem_lat;
        end else if (m_busy && imem_rvalid) begin
          m_busy = 1'b0;
        end else if (m_busy) begin
          m_killed = 1'b1;
        end
        exp_pc = redirect_pc & 32'hFFFF_FFFC;
      end else begin
        if (gnt_now) begin
          m_busy = 1'b1; m_killed = 1'b0; m_addr = exp_pc; m_cnt = mem_lat;
          exp_pc = exp_pc + 32'd4;
        end else if (m_busy && imem_rvalid) begin
          if (!m_killed) sb_q.push_back('{pc: m_addr, code: imem_rdata});
          m_busy = 1'b0;
        end
      end
    end
  endtask

  // One clock: scoreboard at the falling edge, memory response just after the rising edge.
  task automatic tick();
    @(negedge clk);
    monitor_cycle();
    @(posedge clk);
    #1;
    if (reset) begin
      m_busy      = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end else begin
      if (m_busy && m_cnt > 0) m_cnt--;
      imem_rvalid = m_busy && (m_cnt == 0);
      imem_rdata  = imem_rvalid ? (ovr_en ? rdata_ovr : mem_word(m_addr)) : 32'h0;
    end
    redirect = 1'b0;
  endtask

  task automatic wait_inst_valid(input string name);
    for (int i = 0; i < 40 && inst_valid !== 1'b1; i++) tick();
    checks++;
    if (inst_valid !== 1'b1) begin
      errors++; $display("FAIL %s timeout got inst_valid %b exp 1", name, inst_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if (inst_valid !== 1'b0 || inst_code !== INST_NOP || inst_pc !== 32'h0 || fetch_count !== 32'h0) begin
      errors++;
      $display("FAIL reset_regs got v %b code %h pc %h cnt %0d exp 0 %h 0 0",
               inst_valid, inst_code, inst_pc, fetch_count, INST_NOP);
    end
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RPC) begin
      errors++; $display("FAIL reset_req got %b %h exp 1 %h", imem_req, imem_addr, RPC);
    end
  endtask

  task automatic test_basic();
    gnt_addr_log.delete();
    gnt_cyc_log.delete();
    for (int i = 0; i < 40 && exp_count < 32'd3; i++) tick();
    checks++;
    if (fetch_count !== 32'd3) begin
      errors++; $display("FAIL basic_count got %0d exp 3", fetch_count);
    end
    checks++;
    if (gnt_addr_log.size() < 3) begin
      errors++; $display("FAIL basic_grants got %0d exp >=3", gnt_addr_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (gnt_addr_log[i] !== RPC + 32'(4 * i)) begin
          errors++; $display("FAIL basic_addr%0d got %h exp %h", i, gnt_addr_log[i], RPC + 32'(4 * i));
        end
      end
      checks++;
      if (gnt_cyc_log[1] - gnt_cyc_log[0] != 2 || gnt_cyc_log[2] - gnt_cyc_log[1] != 2) begin
        errors++; $display("FAIL basic_spacing got %0d %0d exp 2 2",
                           gnt_cyc_log[1] - gnt_cyc_log[0], gnt_cyc_log[2] - gnt_cyc_log[1]);
      end
    end
  endtask

  task automatic test_redirect_xfer();
    id_ready = 1'b1;
    for (int i = 0; i < 40 && exp_count < 32'd7; i++) tick();
    id_ready = 1'b0;
    for (int i = 0; i < 40 && sb_q.size() == 0; i++) tick();
    id_ready    = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0500;
    tick();
    checks++;
    if (fetch_count !== 32'd8 || inst_valid !== 1'b0 || inst_code !== INST_NOP) begin
      errors++; $display("FAIL redir_xfer got cnt %0d v %b code %h exp 8 0 %h",
                         fetch_count, inst_valid, inst_code, INST_NOP);
    end
    wait_inst_valid("redir_xfer_refill");
  endtask

  task automatic test_stall();
    exp_t held;
    int   ngnt;
    id_ready = 1'b0;
    for (int i = 0; i < 40 && sb_q.size() == 0; i++) tick();
    held = sb_q[0];
    ngnt = gnt_addr_log.size();
    for (int k = 0; k < 5; k++) begin
      tick();
      #1;
      checks++;
      if (inst_code !== held.code || inst_pc !== held.pc || imem_req !== 1'b0) begin
        errors++; $display("FAIL stall%0d got code %h pc %h req %b exp %h %h 0",
                           k, inst_code, inst_pc, imem_req, held.code, held.pc);
      end
    end
    checks++;
    if (gnt_addr_log.size() != ngnt) begin
      errors++; $display("FAIL stall_grants got %0d exp %0d", gnt_addr_log.size(), ngnt);
    end
    id_ready = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_redirect_wait();
    mem_lat   = 2;
    ovr_en    = 1'b1;
    rdata_ovr = 32'hDEAD_BEEF;
    for (int i = 0; i < 40 && !(m_busy && !imem_rvalid && m_cnt > 0); i++) tick();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0203;
    tick();
    for (int i = 0; i < 10 && m_busy; i++) tick();
    ovr_en  = 1'b0;
    mem_lat = 1;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0200 || inst_valid !== 1'b0) begin
      errors++; $display("FAIL redir_wait_addr got req %b addr %h v %b exp 1 00000200 0",
                         imem_req, imem_addr, inst_valid);
    end
    wait_inst_valid("redir_wait_fill");
    checks++;
    if (inst_pc !== 32'h0000_0200 || inst_code !== mem_word(32'h0000_0200)) begin
      errors++; $display("FAIL redir_wait_inst got %h %h exp 00000200 %h",
                         inst_pc, inst_code, mem_word(32'h0000_0200));
    end
  endtask

  task automatic test_redirect_rvalid();
    for (int i = 0; i < 40 && !(m_busy && imem_rvalid); i++) tick();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0300;
    tick();
    #1;
    checks++;
    if (inst_valid !== 1'b0 || inst_code !== INST_NOP || imem_addr !== 32'h0000_0300) begin
      errors++; $display("FAIL redir_rvalid got v %b code %h addr %h exp 0 %h 00000300",
                         inst_valid, inst_code, imem_addr, INST_NOP);
    end
    wait_inst_valid("redir_rvalid_fill");
    checks++;
    if (inst_pc !== 32'h0000_0300) begin
      errors++; $display("FAIL redir_rvalid_pc got %h exp 00000300", inst_pc);
    end
  endtask

  task automatic test_redirect_grant();
    for (int i = 0; i < 40 && !(!m_busy && (sb_q.size() == 0 || id_ready)); i++) tick();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0402;
    tick();
    wait_inst_valid("redir_gnt_fill");
    checks++;
    if (inst_pc !== 32'h0000_0400 || inst_code !== mem_word(32'h0000_0400)) begin
      errors++; $display("FAIL redir_gnt_inst got %h %h exp 00000400 %h",
                         inst_pc, inst_code, mem_word(32'h0000_0400));
    end
    repeat (4) tick();
  endtask

  task automatic test_reset_mid_wait();
    mem_lat = 2;
    for (int i = 0; i < 40 && !(m_busy && !imem_rvalid); i++) tick();
    reset = 1'b1;
    tick();
    reset   = 1'b0;
    mem_lat = 1;
    #1;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RPC || fetch_count !== 32'h0 || inst_valid !== 1'b0) begin
      errors++; $display("FAIL reset_mid_wait got req %b addr %h cnt %0d v %b exp 1 %h 0 0",
                         imem_req, imem_addr, fetch_count, inst_valid, RPC);
    end
    repeat (8) tick();
  endtask

  initial begin
    reset       = 1'b1;
    imem_gnt    = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    id_ready    = 1'b1;
    test_reset();
    test_basic();
    test_redirect_xfer();
    test_stall();
    test_redirect_wait();
    test_redirect_rvalid();
    test_redirect_grant();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
